// File: rtl/pie_encoder.sv
// PIE forward-link framer: latches one command and drives the modulator bit as
// delimiter, data-0, RTcal, optional TRcal, then payload symbols MSB-first.
module pie_encoder #(
    parameter int unsigned MAX_BITS  = 64,
    parameter int unsigned TARI_CYC  = 25,
    parameter int unsigned PW_CYC    = 12,
    parameter int unsigned DELIM_CYC = 25,
    parameter int unsigned TRCAL_CYC = 134,
    parameter int unsigned GAP_CYC   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [MAX_BITS-1:0]             cmd_dat,
    input  logic [$clog2(MAX_BITS+1)-1:0]   cmd_len,
    input  logic                            cmd_preamble,
    input  logic                            cmd_vld,
    output logic                            cmd_rdy,
    output logic                            tx_out,
    output logic                            tx_busy,
    output logic                            tx_done
);

    localparam int unsigned LEN_W   = $clog2(MAX_BITS + 1);
    localparam int unsigned IDX_W   = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam int unsigned D1_CYC  = 2 * TARI_CYC;
    localparam int unsigned RT_CYC  = 3 * TARI_CYC;
    localparam int unsigned MAX_A   = (RT_CYC > TRCAL_CYC) ? RT_CYC : TRCAL_CYC;
    localparam int unsigned MAX_B   = (DELIM_CYC > GAP_CYC) ? DELIM_CYC : GAP_CYC;
    localparam int unsigned MAX_SYM = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(MAX_SYM + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELIM,
        S_DATA0,
        S_RTCAL,
        S_TRCAL,
        S_BITS,
        S_GAP
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [MAX_BITS-1:0]   dat_q, dat_nxt;
    logic [LEN_W-1:0]      len_q, len_nxt;
    logic                  pre_q, pre_nxt;
    logic                  tx_out_nxt, tx_done_nxt, tx_busy_nxt, cmd_rdy_nxt;

    logic                  last;
    logic [IDX_W-1:0]      first_idx, next_idx;
    logic [CNT_W-1:0]      first_len, next_len;

    // Symbol lengths for the first payload bit and the one after the current bit
    always_comb begin
        last      = (cnt == CNT_W'(1));
        first_idx = IDX_W'(len_q - LEN_W'(1));
        next_idx  = idx - IDX_W'(1);
        first_len = dat_q[first_idx] ? CNT_W'(D1_CYC) : CNT_W'(TARI_CYC);
        next_len  = dat_q[next_idx]  ? CNT_W'(D1_CYC) : CNT_W'(TARI_CYC);
    end

    // Next-state, counter and registered-output decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        dat_nxt   = dat_q;
        len_nxt   = len_q;
        pre_nxt   = pre_q;

        if (state != S_IDLE) begin
            cnt_nxt = cnt - CNT_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (cmd_vld) begin
                    state_nxt = S_DELIM;
                    cnt_nxt   = CNT_W'(DELIM_CYC);
                    dat_nxt   = cmd_dat;
                    len_nxt   = (cmd_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : cmd_len;
                    pre_nxt   = cmd_preamble;
                end
            end
            S_DELIM: begin
                if (last) begin
                    state_nxt = S_DATA0;
                    cnt_nxt   = CNT_W'(TARI_CYC);
                end
            end
            S_DATA0: begin
                if (last) begin
                    state_nxt = S_RTCAL;
                    cnt_nxt   = CNT_W'(RT_CYC);
                end
            end
            S_RTCAL: begin
                if (last) begin
                    if (pre_q) begin
                        state_nxt = S_TRCAL;
                        cnt_nxt   = CNT_W'(TRCAL_CYC);
                    end else if (len_q != '0) begin
                        state_nxt = S_BITS;
                        idx_nxt   = first_idx;
                        cnt_nxt   = first_len;
                    end else begin
                        state_nxt = S_GAP;
                        cnt_nxt   = CNT_W'(GAP_CYC);
                    end
                end
            end
            S_TRCAL: begin
                if (last) begin
                    if (len_q != '0) begin
                        state_nxt = S_BITS;
                        idx_nxt   = first_idx;
                        cnt_nxt   = first_len;
                    end else begin
                        state_nxt = S_GAP;
                        cnt_nxt   = CNT_W'(GAP_CYC);
                    end
                end
            end
            S_BITS: begin
                if (last) begin
                    if (idx == '0) begin
                        state_nxt = S_GAP;
                        cnt_nxt   = CNT_W'(GAP_CYC);
                    end else begin
                        idx_nxt = next_idx;
                        cnt_nxt = next_len;
                    end
                end
            end
            S_GAP: begin
                if (last) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Symbols are CW until the final PW_CYC cycles of their down-count
        tx_out_nxt = 1'b1;
        case (state_nxt)
            S_DELIM:                          tx_out_nxt = 1'b0;
            S_DATA0, S_RTCAL, S_TRCAL, S_BITS: tx_out_nxt = (cnt_nxt > CNT_W'(PW_CYC));
            default:                          tx_out_nxt = 1'b1;
        endcase

        tx_done_nxt = (state_nxt == S_GAP) && (state != S_GAP);
        tx_busy_nxt = (state_nxt != S_IDLE);
        cmd_rdy_nxt = (state_nxt == S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            dat_q   <= '0;
            len_q   <= '0;
            pre_q   <= 1'b0;
            tx_out  <= 1'b1;
            tx_done <= 1'b0;
            tx_busy <= 1'b0;
            cmd_rdy <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            dat_q   <= dat_nxt;
            len_q   <= len_nxt;
            pre_q   <= pre_nxt;
            tx_out  <= tx_out_nxt;
            tx_done <= tx_done_nxt;
            tx_busy <= tx_busy_nxt;
            cmd_rdy <= cmd_rdy_nxt;
        end
    end

endmodule
